uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver. Successor to the fixed 8N1 receiver: configurable data width, parity, stop-bit count and oversampling, with 3-sample majority voting, glitch rejection, parity/framing error reporting, and a valid/ready output register with overrun detection. Sits between the synchronised pad input and the byte-stream consumer (command parser or RX FIFO).

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_os_if.sv | 24 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_os.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_os.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states
// and the oversampling clock divider, also used by the TX side.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Clocks per oversample tick, truncated.
   function automatic int unsigned baud_div(
      input int unsigned clk_freq,
      input int unsigned baud,
      input int unsigned os
   );
      return clk_freq / (baud * os);
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver output stream: word, error flags, valid/ready, overrun.
// master = receiver (drives data/flags/valid), slave = consumer (drives ready).
interface uart_rx_os_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] o_data;
   logic                 o_valid;
   logic                 i_ready;
   logic                 o_parity_err;
   logic                 o_frame_err;
   logic                 o_overrun;

   modport master (
      output o_data, o_valid, o_parity_err,
      output o_frame_err, o_overrun,
      input  i_ready
   );

   modport slave (
      input  o_data, o_valid, o_parity_err,
      input  o_frame_err, o_overrun,
      output i_ready
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
// Ports: i_clk, i_reset_n, restart (zero the count), tick (out).
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 25000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic restart,
   output logic tick
);
   localparam int unsigned DIV =
      baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

   if (DIV < 2) begin : g_bad_div
      $error("uart_baud_tick: DIV below 2");
   end

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote and registered output.
// Ports: i_clk, i_reset_n, i_serial (raw line), rx (stream master).
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 25000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int          DATA_BITS  = 8,
   parameter int          PARITY     = 0,
   parameter int          STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_serial,
   uart_rx_os_if.master rx
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [SW-1:0] T_A   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] T_B   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] T_C   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] T_END = SW'(OVERSAMPLE - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 ||
       (OVERSAMPLE != 8 && OVERSAMPLE != 16) ||
       PARITY < 0 || PARITY > 2) begin : g_bad_cfg
      $error("uart_rx_os: illegal configuration");
   end

   state_t               state, nstate;
   logic                 sync1, line;
   logic [1:0]           primed;
   logic                 armed;
   logic                 tick, restart;
   logic [SW-1:0]        samp;
   logic [BW-1:0]        bit_cnt;
   logic                 v0, v1, maj;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc, fe_acc, stop_cnt;
   logic                 decide, bit_end, last_stop;
   logic                 take_bit, take_par, take_stop;
   logic                 done, par_bad, accept;

   uart_baud_tick #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .restart  (restart),
      .tick     (tick)
   );

   assign decide    = tick && (samp == T_C);
   assign bit_end   = tick && (samp == T_END);
   assign maj       = (v0 & v1) | (v0 & line) | (v1 & line);
   assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
   assign accept    = rx.o_valid && rx.i_ready;

   // primed keeps the reset value of the synchroniser from arming
   // the start detector before the real line level has arrived.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1  <= 1'b1;
         line   <= 1'b1;
         primed <= 2'b00;
         armed  <= 1'b0;
      end else begin
         sync1  <= i_serial;
         line   <= sync1;
         primed <= {primed[0], 1'b1};
         armed  <= (state == S_IDLE) && primed[1] && line;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE:
            if (restart) nstate = S_START;
         S_START:
            if (decide && maj) nstate = S_IDLE;
            else if (bit_end)  nstate = S_DATA;
         S_DATA:
            if (bit_end && bit_cnt == BW'(DATA_BITS))
               nstate = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
         S_PARITY:
            if (bit_end) nstate = S_STOP;
         S_STOP:
            if (done) nstate = S_IDLE;
         default:
            nstate = S_IDLE;
      endcase
   end

   always_comb begin
      restart   = 1'b0;
      take_bit  = 1'b0;
      take_par  = 1'b0;
      take_stop = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE:   restart  = armed && !line;
         S_DATA:   take_bit = decide;
         S_PARITY: take_par = decide;
         S_STOP: begin
            take_stop = decide;
            done      = decide && last_stop;
         end
         default: ;
      endcase
      par_bad = 1'b0;
      if (PARITY == PAR_EVEN)     par_bad = par_acc;
      else if (PARITY == PAR_ODD) par_bad = ~par_acc;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         samp     <= '0;
         bit_cnt  <= '0;
         v0       <= 1'b1;
         v1       <= 1'b1;
         shreg    <= '0;
         par_acc  <= 1'b0;
         fe_acc   <= 1'b0;
         stop_cnt <= 1'b0;
      end else begin
         if (tick) samp <= (samp == T_END) ? '0 : samp + SW'(1);
         if (tick && samp == T_A) v0 <= line;
         if (tick && samp == T_B) v1 <= line;
         if (take_bit) begin
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            par_acc <= par_acc ^ maj;
         end
         if (take_par) par_acc <= par_acc ^ maj;
         if (take_stop && !maj) fe_acc <= 1'b1;
         if (state == S_STOP && bit_end) stop_cnt <= 1'b1;
         if (restart) begin
            samp     <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            fe_acc   <= 1'b0;
            stop_cnt <= 1'b0;
         end
      end
   end

   // A frame that completes while the old word is still pending
   // and not being taken this cycle is dropped and flagged.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx.o_data       <= '0;
         rx.o_valid      <= 1'b0;
         rx.o_parity_err <= 1'b0;
         rx.o_frame_err  <= 1'b0;
         rx.o_overrun    <= 1'b0;
      end else begin
         if (accept) rx.o_overrun <= 1'b0;
         if (done && (!rx.o_valid || accept)) begin
            rx.o_data       <= shreg;
            rx.o_parity_err <= par_bad;
            rx.o_frame_err  <= fe_acc | ~maj;
            rx.o_valid      <= 1'b1;
         end else if (done) begin
            rx.o_overrun <= 1'b1;
         end else if (accept) begin
            rx.o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench: three receivers (8N1, 8E1, 7O2) at DIV=10,
// frames driven bit by bit, outputs captured at the falling edge.
module tb_uart_rx_os;
   import uart_pkg::*;

   localparam int CF  = 18432000;
   localparam int BR  = 115200;
   localparam int OS  = 16;
   localparam int BIT = 160;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ser_a = 1'b1;
   logic ser_b = 1'b1;
   logic ser_c = 1'b1;
   logic rdy_a = 1'b1;

   always #5 clk = ~clk;

   uart_rx_os_if #(.DATA_BITS(8)) if_a ();
   uart_rx_os_if #(.DATA_BITS(8)) if_b ();
   uart_rx_os_if #(.DATA_BITS(7)) if_c ();

   assign if_a.i_ready = rdy_a;
   assign if_b.i_ready = 1'b1;
   assign if_c.i_ready = 1'b1;

   uart_rx_os #(
      .CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)
   ) u_a (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_serial(ser_a), .rx(if_a)
   );

   uart_rx_os #(
      .CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8),
      .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS)
   ) u_b (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_serial(ser_b), .rx(if_b)
   );

   uart_rx_os #(
      .CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7),
      .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(OS)
   ) u_c (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_serial(ser_c), .rx(if_c)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int acc_a = 0, acc_b = 0, acc_c = 0;
   int vhi_a = 0, rise_a = 0;
   logic pv_a = 1'b0;
   logic [15:0] d_a = '0, d_b = '0, d_c = '0;
   logic pe_a = 0, fe_a = 0, pe_b = 0, fe_b = 0, pe_c = 0, fe_c = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (if_a.o_valid) vhi_a++;
      if (if_a.o_valid && !pv_a) rise_a = cyc;
      pv_a = if_a.o_valid;
      if (if_a.o_valid && if_a.i_ready) begin
         acc_a++;
         d_a  = 16'(if_a.o_data);
         pe_a = if_a.o_parity_err;
         fe_a = if_a.o_frame_err;
      end
      if (if_b.o_valid && if_b.i_ready) begin
         acc_b++;
         d_b  = 16'(if_b.o_data);
         pe_b = if_b.o_parity_err;
         fe_b = if_b.o_frame_err;
      end
      if (if_c.o_valid && if_c.i_ready) begin
         acc_c++;
         d_c  = 16'(if_c.o_data);
         pe_c = if_c.o_parity_err;
         fe_c = if_c.o_frame_err;
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int ch, input logic v);
      case (ch)
         0:       ser_a = v;
         1:       ser_b = v;
         default: ser_c = v;
      endcase
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bit 0 of pat is the start bit; line returns high afterwards.
   task automatic send(input int ch,
                       input logic [15:0] pat,
                       input int n);
      for (int i = 0; i < n; i++) begin
         drive(ch, pat[i]);
         idle(BIT);
      end
      drive(ch, 1'b1);
   endtask

   int c0, s0, h0;

   initial begin
      idle(5);
      check("rst_valid", 32'(if_a.o_valid), 0);
      check("rst_data", 32'(if_a.o_data), 0);
      check("rst_perr", 32'(if_b.o_parity_err), 0);
      check("rst_ferr", 32'(if_c.o_frame_err), 0);
      check("rst_ovr", 32'(if_a.o_overrun), 0);
      check("rst_state", 32'(u_a.state), 32'(S_IDLE));
      rst_n = 1'b1;
      idle(50);

      // 8N1 0xA5, timing of o_valid
      c0 = cyc;
      s0 = acc_a;
      h0 = vhi_a;
      send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
      idle(300);
      check("t1_count", acc_a - s0, 1);
      check("t1_data", 32'(d_a), 32'hA5);
      check("t1_perr", 32'(pe_a), 0);
      check("t1_ferr", 32'(fe_a), 0);
      check("t1_vcycles", vhi_a - h0, 1);
      check("t1_latency", rise_a - c0, 1543);

      // 8E1 0x07 with wrong parity bit
      s0 = acc_b;
      send(1, {5'h1f, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
      idle(300);
      check("t2_count", acc_b - s0, 1);
      check("t2_data", 32'(d_b), 32'h07);
      check("t2_perr", 32'(pe_b), 1);
      check("t2_ferr", 32'(fe_b), 0);

      // 7O2 0x55, second stop bit low, then a 3-frame break
      s0 = acc_c;
      send(2, {5'h1f, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 11);
      idle(300);
      check("t3_count", acc_c - s0, 1);
      check("t3_data", 32'(d_c), 32'h55);
      check("t3_ferr", 32'(fe_c), 1);
      check("t3_perr", 32'(pe_c), 0);
      s0 = acc_c;
      drive(2, 1'b0);
      idle(3 * 11 * BIT);
      drive(2, 1'b1);
      idle(400);
      check("t3_brk_count", acc_c - s0, 1);
      check("t3_brk_data", 32'(d_c), 0);
      check("t3_brk_ferr", 32'(fe_c), 1);
      check("t3_brk_perr", 32'(pe_c), 1);
      check("t3_brk_state", 32'(u_c.state), 32'(S_IDLE));

      // 40-clock glitch, then 0x3C
      s0 = acc_a;
      drive(0, 1'b0);
      idle(40);
      drive(0, 1'b1);
      idle(300);
      check("t4_glitch_count", acc_a - s0, 0);
      check("t4_glitch_state", 32'(u_a.state), 32'(S_IDLE));
      send(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 10);
      idle(300);
      check("t4_count", acc_a - s0, 1);
      check("t4_data", 32'(d_a), 32'h3C);
      check("t4_ferr", 32'(fe_a), 0);

      // overrun: 0x11 held, 0x22 dropped
      rdy_a = 1'b0;
      s0 = acc_a;
      send(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
      idle(100);
      check("t5_valid1", 32'(if_a.o_valid), 1);
      check("t5_data1", 32'(if_a.o_data), 32'h11);
      check("t5_ovr1", 32'(if_a.o_overrun), 0);
      send(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
      idle(100);
      check("t5_valid2", 32'(if_a.o_valid), 1);
      check("t5_data2", 32'(if_a.o_data), 32'h11);
      check("t5_ovr2", 32'(if_a.o_overrun), 1);
      check("t5_noacc", acc_a - s0, 0);
      rdy_a = 1'b1;
      idle(1);
      check("t5_acc", acc_a - s0, 1);
      check("t5_accdata", 32'(d_a), 32'h11);
      check("t5_valid3", 32'(if_a.o_valid), 0);
      check("t5_ovr3", 32'(if_a.o_overrun), 0);
      check("t5_hold", 32'(if_a.o_data), 32'h11);
      idle(50);

      // reset during data bit 3 of 0xF0, then 0xC3
      s0 = acc_a;
      drive(0, 1'b0);
      idle(4 * BIT + 60);
      rst_n = 1'b0;
      #3;
      check("t6_rst_data", 32'(if_a.o_data), 0);
      check("t6_rst_valid", 32'(if_a.o_valid), 0);
      check("t6_rst_ovr", 32'(if_a.o_overrun), 0);
      check("t6_rst_state", 32'(u_a.state), 32'(S_IDLE));
      idle(3);
      rst_n = 1'b1;
      idle(90);
      drive(0, 1'b1);
      idle(1500);
      check("t6_noframe", acc_a - s0, 0);
      check("t6_valid", 32'(if_a.o_valid), 0);
      check("t6_state", 32'(u_a.state), 32'(S_IDLE));
      send(0, {6'h3f, 1'b1, 8'hC3, 1'b0}, 10);
      idle(300);
      check("t6_count", acc_a - s0, 1);
      check("t6_data", 32'(d_a), 32'hC3);
      check("t6_perr", 32'(pe_a), 0);
      check("t6_ferr", 32'(fe_a), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
